// File: rtl/mips_pkg.sv
// Shared MIPS definitions: default bus widths and data-memory controller types.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Number of byte-offset bits inside one data word.
  function automatic int DMEM_LSB(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mips_dmem_bank.sv
// Word-organised data memory with a byte-enable write port and a registered read port.
module mips_dmem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] memory [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) memory[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read data is non-zero only in the cycle after a read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= memory[idx];
    else         rdata <= '0;
  end

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Data-memory slave for the MIPS load/store stage: request handshake, wait states,
// byte-enable stores and error responses for misaligned or out-of-range addresses.
module mips_dmem_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W      = MIPS_DATA_W,
  parameter int ADDR_W      = MIPS_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output dmem_state_t         dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and rsp_valid is a one-cycle pulse the
  // requester must take (there is no response backpressure).

  localparam int BE_W   = DATA_W / 8;
  localparam int LSB    = DMEM_LSB(DATA_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FIDX_W = ADDR_W - LSB;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_INIT   = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
  localparam logic [FIDX_W-1:0] DEPTH_IDX  = FIDX_W'(DEPTH);

  dmem_state_t       state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic [FIDX_W-1:0] full_idx;
  logic              addr_err;
  logic              accept;
  logic              enter_resp;
  logic              rsp_err_q;

  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge, before the
  // capture registers are loaded, so the live request is used in IDLE.
  assign cur_we    = (state == IDLE) ? req_we    : cap_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;
  assign cur_be    = (state == IDLE) ? req_be    : cap_be;

  assign full_idx = cur_addr[ADDR_W-1:LSB];
  assign addr_err = (|(cur_addr & ALIGN_MASK)) || (full_idx >= DEPTH_IDX);

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rsp_err_q <= enter_resp && addr_err;
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
      end
    end
  end

  mips_dmem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (enter_resp && cur_we && !addr_err),
    .re    (enter_resp && !cur_we && !addr_err),
    .idx   (full_idx[IDX_W-1:0]),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (rsp_rdata)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Bench for mips_dmem_ctrl: three instances (0, 1 and 3 wait states) share one request bus.
module tb_mips_dmem_ctrl;
  import mips_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BW    = DW / 8;
  localparam int NDUT  = 3;
  localparam int NWORD = 256;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be    = '0;
  logic [NDUT-1:0] ready_vec;

  int errors = 0;
  int checks = 0;

  // Reference memory image, updated at issue time in program order.
  logic [DW-1:0] model_mem [NWORD];

  // ---------------- DUTs and per-DUT monitors ----------------
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    dmem_state_t   dbg_state;

    logic [DW:0] exp_q[$];
    logic        busy      = 1'b0;
    logic        ready_bad = 1'b0;
    int          acc       = 0;
    logic [DW:0] e;

    mips_dmem_ctrl #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .DEPTH       (NWORD),
      .WAIT_CYCLES (WC)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .dbg_state (dbg_state)
    );

    assign ready_vec[g] = req_ready;

    always @(negedge clk) begin
      if (!reset) begin
        exp_q.delete();
        busy      = 1'b0;
        ready_bad = 1'b0;
      end else if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp wc=%0d got err=%b rdata=%h, required no response", WC, rsp_err, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== e) begin
            errors++;
            $display("FAIL rsp_data wc=%0d got err=%b rdata=%h, required err=%b rdata=%h",
                     WC, rsp_err, rsp_rdata, e[DW], e[DW-1:0]);
          end
          checks++;
          if (!busy || (cyc - acc) != WC + 1) begin
            errors++;
            $display("FAIL latency wc=%0d got %0d cycles (busy=%b), required %0d", WC, cyc - acc, busy, WC + 1);
          end
          checks++;
          if (ready_bad || req_ready) begin
            errors++;
            $display("FAIL ready_busy wc=%0d got req_ready high while busy, required low", WC);
          end
        end
        busy = 1'b0;
      end else begin
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== '0) begin
          errors++;
          $display("FAIL idle_outputs wc=%0d got err=%b rdata=%h, required 0/0", WC, rsp_err, rsp_rdata);
        end
        if (busy && req_ready) ready_bad = 1'b1;
        if (req_valid && req_ready) begin
          busy      = 1'b1;
          acc       = cyc;
          ready_bad = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h, required %h", name, act, exp);
    end
  endtask

  // Expected response from the address rules: word index = addr/4, error when
  // misaligned or beyond the array; stores merge only enabled bytes.
  function automatic logic [DW:0] model_op(input logic we, input logic [AW-1:0] addr,
                                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    int unsigned idx;
    logic [DW-1:0] w;
    idx = addr / BW;
    if ((addr % BW) != 0 || idx >= NWORD) return {1'b1, {DW{1'b0}}};
    if (!we) return {1'b0, model_mem[idx]};
    w = model_mem[idx];
    for (int b = 0; b < BW; b++) begin
      if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
    end
    model_mem[idx] = w;
    return {1'b0, {DW{1'b0}}};
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(posedge clk); #1;
    while (ready_vec != '1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (ready_vec != '1) begin
      errors++;
      $display("FAIL ready_timeout got ready=%b, required %b", ready_vec, {NDUT{1'b1}});
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((g_dut[0].exp_q.size() + g_dut[1].exp_q.size() + g_dut[2].exp_q.size()) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((g_dut[0].exp_q.size() + g_dut[1].exp_q.size() + g_dut[2].exp_q.size()) != 0) begin
      errors++;
      $display("FAIL rsp_timeout got %0d/%0d/%0d pending, required 0", g_dut[0].exp_q.size(),
               g_dut[1].exp_q.size(), g_dut[2].exp_q.size());
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [BW-1:0] be);
    logic [DW:0] e;
    wait_ready();
    e = model_op(we, addr, wdata, be);
    g_dut[0].exp_q.push_back(e);
    g_dut[1].exp_q.push_back(e);
    g_dut[2].exp_q.push_back(e);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    // Garbage on the bus while busy must be ignored.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = BW'($urandom);
    wait_drain();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int sel;
    logic [AW-1:0] a;

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", 64'(ready_vec), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(ready_vec), 64'({NDUT{1'b1}}));
    check("rsp_valid_after_reset", 64'({g_dut[0].rsp_valid, g_dut[1].rsp_valid, g_dut[2].rsp_valid}), 64'(0));
    check("rdata_after_reset", 64'(g_dut[0].rsp_rdata | g_dut[1].rsp_rdata | g_dut[2].rsp_rdata), 64'(0));
    check("state_after_reset", 64'(g_dut[1].dbg_state), 64'(IDLE));

    // Basic store then load.
    issue(1'b1, 32'h0, 32'd11, 4'hF);
    issue(1'b0, 32'h0, 32'h0, 4'h0);

    // Initialise the working region through the bus.
    for (int i = 1; i < 16; i++) issue(1'b1, AW'(i * BW), $urandom, 4'hF);

    // Partial byte-enable store.
    issue(1'b1, 32'h4, 32'hAABBCCDD, 4'hF);
    issue(1'b1, 32'h4, 32'h11223344, 4'b0101);
    check("be_merge_w0", 64'(g_dut[0].dut.u_bank.memory[1]), 64'h00000000AA22CC44);
    check("be_merge_w1", 64'(g_dut[1].dut.u_bank.memory[1]), 64'h00000000AA22CC44);
    check("be_merge_w3", 64'(g_dut[2].dut.u_bank.memory[1]), 64'h00000000AA22CC44);
    issue(1'b0, 32'h4, 32'h0, 4'h0);

    // Zero byte enables: acknowledged, no change.
    issue(1'b1, 32'h8, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 32'h8, 32'h0, 4'h0);

    // Error responses: misaligned, just past the end, store out of range.
    issue(1'b0, 32'h2, 32'h0, 4'h0);
    issue(1'b0, 32'h400, 32'h0, 4'h0);
    issue(1'b1, 32'h400, 32'hDEADBEEF, 4'hF);
    issue(1'b1, 32'h3FD, 32'hDEADBEEF, 4'hF);
    check("oob_store_w0", 64'(g_dut[0].dut.u_bank.memory[0]), 64'(model_mem[0]));
    check("oob_store_w3", 64'(g_dut[2].dut.u_bank.memory[0]), 64'(model_mem[0]));
    issue(1'b0, 32'h3FC, 32'h0, 4'h0);

    // Randomised mix of loads and stores.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = AW'($urandom_range(0, 15) * BW + $urandom_range(1, BW - 1));
      else if (sel == 1) a = AW'($urandom_range(NWORD, 4 * NWORD) * BW);
      else               a = AW'($urandom_range(0, 15) * BW);
      issue(1'($urandom), a, $urandom, BW'($urandom));
    end

    for (int i = 0; i < 16; i++) begin
      check($sformatf("mem_w0[%0d]", i), 64'(g_dut[0].dut.u_bank.memory[i]), 64'(model_mem[i]));
      check($sformatf("mem_w1[%0d]", i), 64'(g_dut[1].dut.u_bank.memory[i]), 64'(model_mem[i]));
      check($sformatf("mem_w3[%0d]", i), 64'(g_dut[2].dut.u_bank.memory[i]), 64'(model_mem[i]));
    end

    // Reset while a store is waiting: it must never reach memory.
    issue(1'b1, 32'h8, 32'd7, 4'hF);
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'd99;
    req_be    = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("state_wait_w3", 64'(g_dut[2].dbg_state), 64'(WAIT));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midop_reset", 64'(ready_vec), 64'({NDUT{1'b1}}));
    repeat (5) @(posedge clk);
    #1;
    check("discard_store_w1", 64'(g_dut[1].dut.u_bank.memory[2]), 64'd7);
    check("discard_store_w3", 64'(g_dut[2].dut.u_bank.memory[2]), 64'd7);
    // Without wait states the store committed on its accept edge, before reset.
    check("committed_store_w0", 64'(g_dut[0].dut.u_bank.memory[2]), 64'd99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout got no completion, required finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
